scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux_pkg.sv | 11 +
 rtl/mux_nto1.sv | 16 +
 rtl/scan_mux.sv | 44 ++++
 tb/tb_scan_mux.sv | 124 ++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared mux package; default channel width/count and a clog2 helper for sizing selects
package scan_mux_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHANNELS = 4;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/mux_nto1.sv
// mux_nto1: combinational N-to-1 channel mux; d packed channels (channel k at [k*WIDTH +: WIDTH]), sel index, y selected channel
module mux_nto1 import scan_mux_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS
) (
   input  logic [WIDTH*CHANNELS-1:0] d,
   input  logic [clog2(CHANNELS)-1:0] sel,
   output logic [WIDTH-1:0] y
);
   localparam int SELW = clog2(CHANNELS);
   always_comb begin
      y = '0;
      for (int k = 0; k < CHANNELS; k++)
         if (sel == SELW'(k)) y = d[k*WIDTH +: WIDTH];
   end
endmodule

// File: rtl/scan_mux.sv
// scan_mux: auto-scanning/manual channel mux with registered output; clk, nreset (async low), d, sel, nauto, tick, ng in; y (tri-state), ch, nframe out
module scan_mux import scan_mux_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int SELW = clog2(CHANNELS)
) (
   input  logic clk,
   input  logic nreset,
   input  logic [WIDTH*CHANNELS-1:0] d,
   input  logic [SELW-1:0] sel,
   input  logic nauto,
   input  logic tick,
   input  logic ng,
   output logic [WIDTH-1:0] y,
   output logic [SELW-1:0] ch,
   output logic nframe
);
   localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);
   localparam logic [SELW:0] NCH = (SELW + 1)'(CHANNELS);
   logic [SELW-1:0] cur, cur_nxt;
   logic [WIDTH-1:0] y_reg, y_mux;
   logic wrap, wrap_nxt;
   mux_nto1 #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_mux (.d(d), .sel(cur), .y(y_mux));
   always_comb begin
      wrap_nxt = !nauto && tick && cur == LAST;
      cur_nxt = nauto ? (({1'b0, sel} < NCH) ? sel : cur) : (!tick ? cur : wrap_nxt ? '0 : cur + 1'b1);
   end
   // wrap is held one extra edge so the nframe pulse lines up with ch showing the wrapped channel 0
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         cur <= '0;
         y_reg <= '0;
         ch <= '0;
         nframe <= 1'b1;
         wrap <= 1'b0;
      end else begin
         cur <= cur_nxt;
         y_reg <= y_mux;
         ch <= cur;
         nframe <= !wrap;
         wrap <= wrap_nxt;
      end
   assign y = ng ? 'z : y_reg;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed plus random checks of scan_mux (4- and 3-channel instances) against a behavioural model
module tb_scan_mux;
   logic clk = 1'b0, nreset = 1'b0, nauto = 1'b0, tick = 1'b0, ng = 1'b0;
   logic [63:0] d4;
   logic [47:0] d3;
   logic [1:0] sel = 2'd0;
   logic [15:0] y4, y3;
   logic [1:0] ch4, ch3;
   logic nf4, nf3;
   int tests = 0, fails = 0;
   int nch[2] = '{4, 3};
   int m_cur[2], m_ch[2], m_y[2], m_nf[2];
   bit m_wrap[2];
   always #5 clk = ~clk;
   scan_mux #(.WIDTH(16), .CHANNELS(4)) dut4 (.clk(clk), .nreset(nreset), .d(d4), .sel(sel), .nauto(nauto),
      .tick(tick), .ng(ng), .y(y4), .ch(ch4), .nframe(nf4));
   scan_mux #(.WIDTH(16), .CHANNELS(3)) dut3 (.clk(clk), .nreset(nreset), .d(d3), .sel(sel), .nauto(nauto),
      .tick(tick), .ng(ng), .y(y3), .ch(ch3), .nframe(nf3));
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cur[i] = 0;
         m_ch[i] = 0;
         m_y[i] = 0;
         m_nf[i] = 1;
         m_wrap[i] = 1'b0;
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, "/y4"}, y4, ng ? 16'hzzzz : 16'(m_y[0]));
      chk({tag, "/y3"}, y3, ng ? 16'hzzzz : 16'(m_y[1]));
      chk({tag, "/ch4"}, {14'b0, ch4}, 16'(m_ch[0]));
      chk({tag, "/ch3"}, {14'b0, ch3}, 16'(m_ch[1]));
      chk({tag, "/nframe4"}, {15'b0, nf4}, 16'(m_nf[0]));
      chk({tag, "/nframe3"}, {15'b0, nf3}, 16'(m_nf[1]));
   endtask
   // one clock edge: the model presents the current channel, then moves the pointer by the mode rules
   task automatic step(input string tag);
      int n;
      for (int i = 0; i < 2; i++) begin
         n = nch[i];
         m_y[i] = (i == 0) ? int'(d4[m_cur[0]*16 +: 16]) : int'(d3[m_cur[1]*16 +: 16]);
         m_ch[i] = m_cur[i];
         m_nf[i] = m_wrap[i] ? 0 : 1;
         m_wrap[i] = 1'b0;
         if (!nauto) begin
            if (tick) begin
               m_cur[i] = (m_cur[i] + 1) % n;
               m_wrap[i] = (m_cur[i] == 0);
            end
         end else if (int'(sel) < n) m_cur[i] = int'(sel);
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask
   initial begin
      int lows;
      lows = 0;
      d4 = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
      d3 = {16'hA002, 16'hA001, 16'hA000};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      nreset = 1'b1;
      tick = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step("scan");
         if (i < 7 && !nf3) lows++;
      end
      chk("frames3", 16'(lows), 16'd2);
      ng = 1'b1;
      #1;
      check_all("ng_z");
      step("ng_adv");
      step("ng_adv");
      ng = 1'b0;
      #1;
      check_all("ng_off");
      nauto = 1'b1;
      sel = 2'd2;
      step("man2");
      sel = 2'd3;
      for (int i = 0; i < 4; i++) begin
         tick = ~tick;
         step("man3");
      end
      nauto = 1'b0;
      tick = 1'b1;
      for (int i = 0; i < 8 && m_ch[0] != 2; i++) step("to_ch2");
      #2;
      nreset = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      ng = 1'b1;
      #1;
      check_all("rst_z");
      ng = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      step("post_rst0");
      step("post_rst1");
      repeat (300) begin
         d4 = {$urandom, $urandom};
         d3 = 48'({$urandom, $urandom});
         sel = 2'($urandom);
         nauto = ($urandom_range(0, 3) == 0);
         tick = 1'($urandom);
         ng = ($urandom_range(0, 7) == 0);
         step("rand");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
